// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TMS-steered FSM with Moore scan strobes,
// TDO mux select, TDO enable and a test-logic-reset flag.
module jtag_tap_ctrl (
    input  logic       TCK,
    input  logic       Rst,
    input  logic       TMS,
    output logic [3:0] State,
    output logic       Select,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic       CaptureIR,
    output logic       ShiftIR,
    output logic       UpdateIR,
    output logic       TestLogicReset,
    output logic       TDO_En
);

    typedef enum logic [3:0] {
        S_TLR    = 4'hF, S_RTI    = 4'hC,
        S_SEL_DR = 4'h7, S_CAP_DR = 4'h6, S_SH_DR = 4'h2, S_EX1_DR = 4'h1,
        S_PAU_DR = 4'h3, S_EX2_DR = 4'h0, S_UPD_DR = 4'h5,
        S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA, S_EX1_IR = 4'h9,
        S_PAU_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD
    } tap_state_t;

    tap_state_t state, nxt;

    always_comb begin
        nxt = S_TLR;
        case (state)
            S_TLR:    nxt = TMS ? S_TLR    : S_RTI;
            S_RTI:    nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: nxt = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: nxt = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: nxt = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: nxt = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: nxt = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: nxt = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: nxt = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: nxt = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: nxt = TMS ? S_SEL_DR : S_RTI;
            default:  nxt = S_TLR;
        endcase
    end

    // Outputs are registered from the next-state decode, so they line up
    // exactly with State and carry no path from TMS.
    always_ff @(posedge TCK) begin
        if (Rst) begin
            state          <= S_TLR;
            Select         <= 1'b0;
            CaptureDR      <= 1'b0;
            ShiftDR        <= 1'b0;
            UpdateDR       <= 1'b0;
            CaptureIR      <= 1'b0;
            ShiftIR        <= 1'b0;
            UpdateIR       <= 1'b0;
            TestLogicReset <= 1'b1;
            TDO_En         <= 1'b0;
        end else begin
            state          <= nxt;
            Select         <= (nxt == S_CAP_IR) || (nxt == S_SH_IR)  || (nxt == S_EX1_IR) ||
                              (nxt == S_PAU_IR) || (nxt == S_EX2_IR) || (nxt == S_UPD_IR);
            CaptureDR      <= (nxt == S_CAP_DR);
            ShiftDR        <= (nxt == S_SH_DR);
            UpdateDR       <= (nxt == S_UPD_DR);
            CaptureIR      <= (nxt == S_CAP_IR);
            ShiftIR        <= (nxt == S_SH_IR);
            UpdateIR       <= (nxt == S_UPD_IR);
            TestLogicReset <= (nxt == S_TLR);
            TDO_En         <= (nxt == S_SH_DR) || (nxt == S_SH_IR);
        end
    end

    assign State = state;

endmodule
